// File: rtl/operand_fetch_pkg.sv
// rtl/operand_fetch_pkg.sv - shared widths and FSM encodings for the operand fetch unit
package operand_fetch_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int SEL_W     = 3;
    localparam int NUM_REGS  = 8;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/operand_fetch_regsel.sv
// rtl/operand_fetch_regsel.sv - 8:1 register select with write-back bypass
module regsel8
    import operand_fetch_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [NUM_REGS-1:0][WIDTH-1:0] regs_i,
    input  logic [SEL_W-1:0]               sel_i,
    input  logic                           wb_e_i,
    input  logic [SEL_W-1:0]               wb_sel_i,
    input  logic [WIDTH-1:0]               wb_data_i,
    output logic [WIDTH-1:0]               data_o
);

    // A write landing in the bank this cycle is not visible on its outputs yet, so forward it
    always_comb begin
        if (wb_e_i && (wb_sel_i == sel_i)) begin
            data_o = wb_data_i;
        end else begin
            data_o = regs_i[sel_i];
        end
    end

endmodule

// File: rtl/operand_fetch.sv
// rtl/operand_fetch.sv - two-entry operand fetch stage with bypass and transfer counter
module operand_fetch
    import operand_fetch_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             CLK,
    input  logic             RSTn,
    input  logic [WIDTH-1:0] R0,
    input  logic [WIDTH-1:0] R1,
    input  logic [WIDTH-1:0] R2,
    input  logic [WIDTH-1:0] R3,
    input  logic [WIDTH-1:0] R4,
    input  logic [WIDTH-1:0] R5,
    input  logic [WIDTH-1:0] R6,
    input  logic [WIDTH-1:0] R7,
    input  logic [SEL_W-1:0] SRCA,
    input  logic [SEL_W-1:0] SRCB,
    input  logic             REQ,
    output logic             RDY,
    input  logic             WB_E,
    input  logic [SEL_W-1:0] WB_SEL,
    input  logic [WIDTH-1:0] WB_DATA,
    output logic [WIDTH-1:0] OPA,
    output logic [WIDTH-1:0] OPB,
    output logic             VALID,
    input  logic             ACK,
    output logic [7:0]       CNT
);

    logic [NUM_REGS-1:0][WIDTH-1:0] bank;
    logic [WIDTH-1:0]               cap_a;
    logic [WIDTH-1:0]               cap_b;

    fetch_state_e     state_q, state_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] ska_q, ska_d;
    logic [WIDTH-1:0] skb_q, skb_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             live_q;
    logic             accept;
    logic             take;

    assign bank = {R7, R6, R5, R4, R3, R2, R1, R0};

    regsel8 #(.WIDTH(WIDTH)) u_sel_a (
        .regs_i    (bank),
        .sel_i     (SRCA),
        .wb_e_i    (WB_E),
        .wb_sel_i  (WB_SEL),
        .wb_data_i (WB_DATA),
        .data_o    (cap_a)
    );

    regsel8 #(.WIDTH(WIDTH)) u_sel_b (
        .regs_i    (bank),
        .sel_i     (SRCB),
        .wb_e_i    (WB_E),
        .wb_sel_i  (WB_SEL),
        .wb_data_i (WB_DATA),
        .data_o    (cap_b)
    );

    // Outputs depend only on registered state, so REQ->VALID and ACK->RDY stay registered paths
    assign VALID  = (state_q != ST_EMPTY);
    assign RDY    = live_q && (state_q != ST_TWO);
    assign OPA    = opa_q;
    assign OPB    = opb_q;
    assign CNT    = cnt_q;
    assign accept = REQ && RDY;
    assign take   = VALID && ACK;

    // Next-state: output stage plus one skid entry, results leave in acceptance order
    always_comb begin
        state_d = state_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        ska_d   = ska_q;
        skb_d   = skb_q;
        cnt_d   = cnt_q;
        if (take) begin
            cnt_d = cnt_q + 8'd1;
        end
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    state_d = ST_ONE;
                    opa_d   = cap_a;
                    opb_d   = cap_b;
                end
            end
            ST_ONE: begin
                if (accept && take) begin
                    opa_d = cap_a;
                    opb_d = cap_b;
                end else if (accept) begin
                    state_d = ST_TWO;
                    ska_d   = cap_a;
                    skb_d   = cap_b;
                end else if (take) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (take) begin
                    state_d = ST_ONE;
                    opa_d   = ska_q;
                    opb_d   = skb_q;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
    end

    // State registers update on the falling edge, in step with the register bank
    always_ff @(negedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q <= ST_EMPTY;
            opa_q   <= '0;
            opb_q   <= '0;
            ska_q   <= '0;
            skb_q   <= '0;
            cnt_q   <= 8'd0;
            live_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            ska_q   <= ska_d;
            skb_q   <= skb_d;
            cnt_q   <= cnt_d;
            live_q  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_operand_fetch.sv
// tb/tb_operand_fetch.sv - directed self-checking bench for operand_fetch
module tb_operand_fetch;

    logic       clk;
    logic       rstn;
    logic [7:0] r [8];
    logic [2:0] srca, srcb;
    logic       req, ack;
    logic       wb_e;
    logic [2:0] wb_sel;
    logic [7:0] wb_data;
    logic       rdy, valid;
    logic [7:0] opa, opb, cnt;

    int total;
    int bad;
    int exp_cnt;

    operand_fetch #(.WIDTH(8)) dut (
        .CLK     (clk),
        .RSTn    (rstn),
        .R0      (r[0]),
        .R1      (r[1]),
        .R2      (r[2]),
        .R3      (r[3]),
        .R4      (r[4]),
        .R5      (r[5]),
        .R6      (r[6]),
        .R7      (r[7]),
        .SRCA    (srca),
        .SRCB    (srcb),
        .REQ     (req),
        .RDY     (rdy),
        .WB_E    (wb_e),
        .WB_SEL  (wb_sel),
        .WB_DATA (wb_data),
        .OPA     (opa),
        .OPB     (opb),
        .VALID   (valid),
        .ACK     (ack),
        .CNT     (cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        #3;
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", valid); end
        total++; if (rdy !== 1'b0) begin bad++; $display("FAIL rst_rdy got=%b exp=0", rdy); end
        total++; if ({opa, opb} !== 16'h0000) begin bad++; $display("FAIL rst_ops got=%h exp=0000", {opa, opb}); end
        total++; if (cnt !== 8'd0) begin bad++; $display("FAIL rst_cnt got=%0d exp=0", cnt); end
        req = 1'b1;
        step();
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL rst_hold_valid got=%b exp=0", valid); end
        rstn = 1'b1;
        req  = 1'b0;
        #1;
        total++; if (rdy !== 1'b0) begin bad++; $display("FAIL rst_rdy_pre_edge got=%b exp=0", rdy); end
        step();
        total++; if (rdy !== 1'b1) begin bad++; $display("FAIL rst_rdy_post_edge got=%b exp=1", rdy); end
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL rst_valid_post_edge got=%b exp=0", valid); end
    endtask

    task automatic test_basic();
        r[3] = 8'h5A; r[6] = 8'hC3;
        srca = 3'd3; srcb = 3'd6; req = 1'b1; ack = 1'b1;
        step();
        total++; if (valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%b exp=1", valid); end
        total++; if (opa !== 8'h5A) begin bad++; $display("FAIL basic_opa got=%h exp=5a", opa); end
        total++; if (opb !== 8'hC3) begin bad++; $display("FAIL basic_opb got=%h exp=c3", opb); end
        total++; if (cnt !== 8'd0) begin bad++; $display("FAIL basic_cnt0 got=%0d exp=0", cnt); end
        req = 1'b0;
        step();
        exp_cnt = 1;
        total++; if (cnt !== 8'(exp_cnt)) begin bad++; $display("FAIL basic_cnt1 got=%0d exp=%0d", cnt, exp_cnt); end
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL basic_drained got=%b exp=0", valid); end
    endtask

    task automatic test_r0();
        r[0] = 8'hA5; r[1] = 8'h3E;
        srca = 3'd0; srcb = 3'd1; req = 1'b1; ack = 1'b0;
        step();
        total++; if ({opa, opb} !== 16'hA53E) begin bad++; $display("FAIL r0_ops got=%h exp=a53e", {opa, opb}); end
        req = 1'b0; ack = 1'b1;
        step();
        exp_cnt++;
        total++; if (cnt !== 8'(exp_cnt)) begin bad++; $display("FAIL r0_cnt got=%0d exp=%0d", cnt, exp_cnt); end
    endtask

    task automatic test_bypass();
        r[2] = 8'h11; r[5] = 8'h3C;
        wb_e = 1'b1; wb_sel = 3'd2; wb_data = 8'h77;
        srca = 3'd2; srcb = 3'd5; req = 1'b1; ack = 1'b0;
        step();
        total++; if (opa !== 8'h77) begin bad++; $display("FAIL byp_opa got=%h exp=77", opa); end
        total++; if (opb !== 8'h3C) begin bad++; $display("FAIL byp_opb got=%h exp=3c", opb); end
        req = 1'b0; wb_data = 8'h99; r[5] = 8'h66; r[2] = 8'h22;
        step();
        total++; if ({opa, opb} !== 16'h773C) begin bad++; $display("FAIL byp_snapshot got=%h exp=773c", {opa, opb}); end
        ack = 1'b1;
        step();
        exp_cnt++;
        wb_data = 8'h77; srca = 3'd2; srcb = 3'd2; req = 1'b1; ack = 1'b0;
        step();
        total++; if ({opa, opb} !== 16'h7777) begin bad++; $display("FAIL byp_same_src got=%h exp=7777", {opa, opb}); end
        wb_e = 1'b0; req = 1'b0; ack = 1'b1;
        step();
        exp_cnt++;
        total++; if (cnt !== 8'(exp_cnt)) begin bad++; $display("FAIL byp_cnt got=%0d exp=%0d", cnt, exp_cnt); end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 8; i++) r[i] = 8'hA0 + 8'(i);
        ack = 1'b0; req = 1'b1; srca = 3'd1; srcb = 3'd2;
        step();
        total++; if ({valid, rdy} !== 2'b11) begin bad++; $display("FAIL bp_one got=%b exp=11", {valid, rdy}); end
        srca = 3'd4; srcb = 3'd5;
        step();
        total++; if ({valid, rdy} !== 2'b10) begin bad++; $display("FAIL bp_two got=%b exp=10", {valid, rdy}); end
        total++; if ({opa, opb} !== 16'hA1A2) begin bad++; $display("FAIL bp_head got=%h exp=a1a2", {opa, opb}); end
        srca = 3'd7; srcb = 3'd6;
        step();
        total++; if ({opa, opb, rdy} !== {16'hA1A2, 1'b0}) begin bad++; $display("FAIL bp_stall got=%h exp=%h", {opa, opb, rdy}, {16'hA1A2, 1'b0}); end
        ack = 1'b1;
        step();
        exp_cnt++;
        total++; if ({opa, opb} !== 16'hA4A5) begin bad++; $display("FAIL bp_second got=%h exp=a4a5", {opa, opb}); end
        total++; if (rdy !== 1'b1) begin bad++; $display("FAIL bp_rdy_back got=%b exp=1", rdy); end
        step();
        exp_cnt++;
        total++; if ({opa, opb} !== 16'hA7A6) begin bad++; $display("FAIL bp_third got=%h exp=a7a6", {opa, opb}); end
        req = 1'b0;
        step();
        exp_cnt++;
        total++; if ({valid, cnt} !== {1'b0, 8'(exp_cnt)}) begin bad++; $display("FAIL bp_end got=%h exp=%h", {valid, cnt}, {1'b0, 8'(exp_cnt)}); end
    endtask

    task automatic test_accept_take();
        ack = 1'b0; req = 1'b1; srca = 3'd1; srcb = 3'd0;
        step();
        srca = 3'd2; srcb = 3'd3; ack = 1'b1;
        step();
        exp_cnt++;
        total++; if ({valid, rdy} !== 2'b11) begin bad++; $display("FAIL at_state got=%b exp=11", {valid, rdy}); end
        total++; if ({opa, opb} !== 16'hA2A3) begin bad++; $display("FAIL at_ops got=%h exp=a2a3", {opa, opb}); end
        total++; if (cnt !== 8'(exp_cnt)) begin bad++; $display("FAIL at_cnt got=%0d exp=%0d", cnt, exp_cnt); end
        req = 1'b0;
        step();
        exp_cnt++;
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL at_drain got=%b exp=0", valid); end
    endtask

    task automatic test_reset_mid_two();
        ack = 1'b0; req = 1'b1; srca = 3'd3; srcb = 3'd4;
        step();
        step();
        total++; if ({valid, rdy} !== 2'b10) begin bad++; $display("FAIL rm_two got=%b exp=10", {valid, rdy}); end
        rstn = 1'b0;
        #1;
        total++; if ({valid, rdy} !== 2'b00) begin bad++; $display("FAIL rm_flags got=%b exp=00", {valid, rdy}); end
        total++; if ({opa, opb, cnt} !== 24'h0) begin bad++; $display("FAIL rm_regs got=%h exp=000000", {opa, opb, cnt}); end
        req = 1'b0;
        step();
        rstn = 1'b1;
        step();
        total++; if (rdy !== 1'b1) begin bad++; $display("FAIL rm_rdy got=%b exp=1", rdy); end
        ack = 1'b1;
        step();
        total++; if ({valid, cnt} !== 9'h0) begin bad++; $display("FAIL rm_no_stale got=%h exp=000", {valid, cnt}); end
        exp_cnt = 0;
    endtask

    task automatic test_wrap();
        req = 1'b1; ack = 1'b1; srca = 3'd0; srcb = 3'd7;
        for (int i = 0; i < 256; i++) step();
        total++; if (cnt !== 8'd255) begin bad++; $display("FAIL wrap_255 got=%0d exp=255", cnt); end
        step();
        total++; if (cnt !== 8'd0) begin bad++; $display("FAIL wrap_256 got=%0d exp=0", cnt); end
        step();
        total++; if (cnt !== 8'd1) begin bad++; $display("FAIL wrap_257 got=%0d exp=1", cnt); end
        req = 1'b0;
        step();
    endtask

    initial begin
        total = 0; bad = 0; exp_cnt = 0;
        rstn = 1'b0; req = 1'b0; ack = 1'b0;
        srca = 3'd0; srcb = 3'd0;
        wb_e = 1'b0; wb_sel = 3'd0; wb_data = 8'h00;
        for (int i = 0; i < 8; i++) r[i] = 8'h00;
        test_reset();
        test_basic();
        test_r0();
        test_bypass();
        test_backpressure();
        test_accept_take();
        test_reset_mid_two();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
